// File: rtl/test_pattern_gen.sv
// Rate-controlled test pattern source (count / LFSR / constant / walking-one)
// with valid/ready handshake, optional burst length and restart handling.
module test_pattern_gen #(
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic        restart_in,
  input  logic [1:0]  mode_in,
  input  logic [7:0]  constData_in,
  input  logic [3:0]  ceiling_in,
  input  logic [7:0]  burstLen_in,
  output logic [7:0]  outputData_out,
  output logic        outputValid_out,
  input  logic        outputReady_in,
  output logic [15:0] itemCount_out,
  output logic        done_out
);

  localparam logic [7:0] SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [1:0] M_COUNT = 2'b00;
  localparam logic [1:0] M_LFSR  = 2'b01;
  localparam logic [1:0] M_CONST = 2'b10;
  localparam logic [1:0] M_WALK  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  const_q, const_d;
  logic [3:0]  ceil_q, ceil_d;
  logic [7:0]  blen_q, blen_d;
  logic [7:0]  pat_q, pat_d;
  logic [7:0]  burst_q, burst_d;
  logic [3:0]  presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rst_pend_q, rst_pend_d;
  // Pattern reload is deferred to the next IDLE start so it can use the
  // mode latched at that moment.
  logic        reload_q, reload_d;
  logic [7:0]  burst_nxt;
  logic        accept;

  function automatic logic [7:0] reload_val(input logic [1:0] m);
    case (m)
      M_COUNT: return 8'h00;
      M_LFSR:  return SEED;
      M_WALK:  return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] advance(input logic [1:0] m, input logic [7:0] p);
    case (m)
      M_COUNT: return p + 8'h01;
      M_LFSR:  return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
      M_WALK:  return {p[6:0], p[7]};
      default: return p;
    endcase
  endfunction

  assign accept = (state_q == S_OFFER) && outputReady_in;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    const_d    = const_q;
    ceil_d     = ceil_q;
    blen_d     = blen_q;
    pat_d      = pat_q;
    burst_d    = burst_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    rst_pend_d = rst_pend_q;
    reload_d   = reload_q;
    burst_nxt  = burst_q + 8'h01;
    case (state_q)
      S_IDLE: begin
        if (restart_in) begin
          reload_d = 1'b1;
          burst_d  = '0;
          presc_d  = '0;
        end else if (enable_in) begin
          mode_d  = mode_in;
          const_d = constData_in;
          ceil_d  = ceiling_in;
          blen_d  = burstLen_in;
          presc_d = '0;
          if (reload_q) begin
            pat_d    = reload_val(mode_in);
            reload_d = 1'b0;
          end
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (restart_in) rst_pend_d = 1'b1;
        if (accept) begin
          cnt_d   = cnt_q + 16'h0001;
          pat_d   = advance(mode_q, pat_q);
          burst_d = burst_nxt;
          if (rst_pend_q || restart_in) begin
            state_d    = S_IDLE;
            reload_d   = 1'b1;
            burst_d    = '0;
            presc_d    = '0;
            rst_pend_d = 1'b0;
          end else if (blen_q != 8'h00 && burst_nxt >= blen_q) begin
            state_d = S_DONE;
          end else if (!enable_in) begin
            state_d = S_IDLE;
          end else if (ceil_q != 4'h0) begin
            state_d = S_WAIT;
            presc_d = 4'h1;
          end
        end
      end
      S_WAIT: begin
        if (restart_in) begin
          state_d  = S_IDLE;
          reload_d = 1'b1;
          burst_d  = '0;
          presc_d  = '0;
        end else if (!enable_in) begin
          state_d = S_IDLE;
        end else if (presc_q == ceil_q) begin
          state_d = S_OFFER;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 4'h1;
        end
      end
      S_DONE: begin
        if (restart_in) begin
          state_d  = S_IDLE;
          reload_d = 1'b1;
          burst_d  = '0;
          presc_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      mode_q     <= M_COUNT;
      const_q    <= '0;
      ceil_q     <= '0;
      blen_q     <= '0;
      pat_q      <= '0;
      burst_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      rst_pend_q <= 1'b0;
      reload_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      const_q    <= const_d;
      ceil_q     <= ceil_d;
      blen_q     <= blen_d;
      pat_q      <= pat_d;
      burst_q    <= burst_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      rst_pend_q <= rst_pend_d;
      reload_q   <= reload_d;
    end
  end

  // Outputs depend on registered state only, never on outputReady_in.
  assign outputValid_out = (state_q == S_OFFER);
  assign done_out        = (state_q == S_DONE);
  assign outputData_out  = (mode_q == M_CONST) ? const_q : pat_q;
  assign itemCount_out   = cnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Directed bench for test_pattern_gen: expected bytes are queued ahead of
// each run and popped by a monitor as the DUT hands them over.
module tb_test_pattern_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  cdata = 8'h00;
  logic [3:0]  ceil = 4'h0;
  logic [7:0]  blen = 8'h00;
  logic [7:0]  odata;
  logic        ovalid;
  logic        oready = 1'b0;
  logic [15:0] icount;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_acc = -1;
  int gap_exp  = 0;
  logic [7:0] sb[$];

  test_pattern_gen #(.LFSR_SEED(8'h01)) dut (
    .clk_in(clk), .reset_in(rst_n), .enable_in(enable), .restart_in(restart),
    .mode_in(mode), .constData_in(cdata), .ceiling_in(ceil), .burstLen_in(blen),
    .outputData_out(odata), .outputValid_out(ovalid), .outputReady_in(oready),
    .itemCount_out(icount), .done_out(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept happens at the posedge following this negedge sample.
  always @(negedge clk) begin
    if (ovalid && oready) begin
      if (sb.size() == 0) begin
        chk("unexpected_item", {24'h0, odata}, 32'hFFFF_FFFF);
      end else begin
        chk("item_data", {24'h0, odata}, {24'h0, sb.pop_front()});
        if (gap_exp != 0 && last_acc >= 0) chk("item_gap", cyc - last_acc, gap_exp);
        last_acc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #2; n++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; enable = 1'b0; oready = 1'b0; restart = 1'b0;
    tick(1);
    rst_n = 1'b1;
    last_acc = -1;
    tick(1);
  endtask

  initial begin
    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", ovalid, 0);
    chk("rst_done", done, 0);
    chk("rst_count", icount, 0);
    chk("rst_data", odata, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Count mode, back-to-back, wrap FF->00
    mode = 2'b00; ceil = 4'h0; blen = 8'h00; oready = 1'b1; gap_exp = 1;
    for (int i = 0; i < 258; i++) sb.push_back(8'(i));
    enable = 1'b1;
    drain("count_drain", 400);
    oready = 1'b0;
    chk("count_total", icount, 16'd258);

    // LFSR, ceiling 3: accepts four cycles apart
    do_reset();
    mode = 2'b01; ceil = 4'h3; oready = 1'b1; gap_exp = 4;
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h04);
    sb.push_back(8'h08); sb.push_back(8'h11); sb.push_back(8'h23);
    enable = 1'b1;
    drain("lfsr_drain", 100);
    oready = 1'b0;
    chk("lfsr_total", icount, 16'd6);

    // Walking one, burst 3, with a five-cycle stall on the first item
    do_reset();
    mode = 2'b11; ceil = 4'h0; blen = 8'd3; oready = 1'b0; gap_exp = 0;
    sb.push_back(8'h01); sb.push_back(8'h02); sb.push_back(8'h04);
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", ovalid, 1);
      chk("stall_data", odata, 8'h01);
      tick(1);
    end
    oready = 1'b1;
    drain("walk_drain", 50);
    chk("walk_done", done, 1);
    chk("walk_valid", ovalid, 0);
    chk("walk_total", icount, 16'd3);
    tick(3);
    chk("walk_done_hold", done, 1);
    chk("walk_valid_hold", ovalid, 0);

    // Restart pulsed during a stalled offer
    do_reset();
    mode = 2'b00; blen = 8'h00; oready = 1'b0;
    enable = 1'b1;
    tick(1);
    mode = 2'b01;
    tick(1);
    chk("rst_pend_data", odata, 8'h00);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    mode = 2'b00;
    tick(1);
    sb.push_back(8'h00); sb.push_back(8'h00);
    oready = 1'b1;
    drain("restart_drain", 50);
    oready = 1'b0;
    chk("restart_total", icount, 16'd2);
    chk("restart_offer", ovalid, 1);

    // Reset in the middle of an offer
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ovalid, 0);
    chk("midrst_count", icount, 0);
    chk("midrst_data", odata, 0);
    tick(1);
    rst_n = 1'b1; enable = 1'b0;
    tick(1);

    // Constant mode: item counter up to FFFF and wrap
    mode = 2'b10; cdata = 8'hA5; ceil = 4'h0; blen = 8'h00; gap_exp = 0;
    for (int i = 0; i < 65535; i++) sb.push_back(8'hA5);
    oready = 1'b1; enable = 1'b1;
    tick(1);
    cdata = 8'h3C;
    drain("wrap_drain", 70000);
    oready = 1'b0;
    chk("count_ffff", icount, 16'hFFFF);
    sb.push_back(8'hA5);
    oready = 1'b1;
    drain("wrap_last", 20);
    oready = 1'b0;
    chk("count_wrap", icount, 16'h0000);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
